memory_access: RTL and testbench
================================

# memory_access

Memory-access stage of the pipelined RV64 core, directly upstream of writeback. Accepts one instruction per handshake from execute, issues loads/stores on the data bus, aligns and sign/zero-extends load data, and produces the registered result bundle (destination, write-enable, data) that writeback consumes. Non-memory instructions pass through with one cycle of latency. Memory instructions stall the upstream stage until the bus transaction completes.

## Interface
- XLEN, 64, datapath and address width
- REG_AW, 5, register-index width
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  execute presents an instruction
- in_ready  out  1  stage accepts; transfer when in_valid && in_ready
- in_mem_op  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU, 8 SB, 9 SH, 10 SW, 11 SD; 12–15 treated as NONE
- in_addr  in  XLEN  ALU result; the effective address for memory ops
- in_wdata  in  XLEN  store source register value
- in_dst  in  REG_AW  destination register
- in_wen  in  1  instruction writes in_dst
- dreq_valid  out  1  bus request valid
- dreq_addr  out  XLEN  request address, unmodified in_addr
- dreq_size  out  3  0 byte, 1 half, 2 word, 3 dword
- dreq_strobe  out  8  byte-lane write enables; 0 for loads
- dreq_data  out  XLEN  store data, lane-shifted
- dresp_addr_ok  in  1  request accepted by bus
- dresp_data_ok  in  1  transaction complete
- dresp_data  in  XLEN  aligned 64-bit read data
- out_valid  out  1  one-cycle pulse per completed instruction
- out_dst  out  REG_AW  destination to writeback
- out_wen  out  1  register write enable to writeback
- out_data  out  XLEN  result to writeback
- out_exc  out  1  misaligned-access exception

## Operation
- The FSM has three states: IDLE, REQ and WAIT. in_ready = (state==IDLE).
- IDLE, transfer, NONE op: the output registers load in_dst, in_wen and in_addr, with out_exc=0. The FSM stays in IDLE.
- IDLE, transfer, misaligned memory op: no bus request is issued. The output registers load out_wen=0, out_data=0 and out_exc=1. The FSM stays in IDLE.
  - LH/LHU/SH are misaligned when addr[0]≠0.
  - LW/LWU/SW are misaligned when addr[1:0]≠0.
  - LD/SD are misaligned when addr[2:0]≠0.
- IDLE, transfer, aligned memory op: op, address, wdata, dst and wen are latched. The FSM goes to REQ.
- REQ: dreq_valid=1, driven from the latched fields.
  - addr_ok && data_ok: complete; go to IDLE.
  - addr_ok only: go to WAIT.
  - Neither: hold; request fields stay stable.
- WAIT: dreq_valid=0. data_ok completes the instruction and returns to IDLE.
- Store request fields, with off=addr[2:0]:
  - dreq_data = wdata << (8·off).
  - dreq_strobe = (size mask) << off, where the size mask is 0x01, 0x03, 0x0F or 0xFF.
- Load result: dresp_data >> (8·off), truncated to the access size.
  - LB/LH/LW sign-extend to 64 bits.
  - LBU/LHU/LWU zero-extend. LD is used as is.
- On completion the output registers load the values below, and out_valid pulses for one cycle.
  - Load: out_wen = latched wen, out_data = extended load data.
  - Store: out_wen=0, out_data=0.
- out_valid is 0 in every cycle where no instruction completed. out_dst, out_wen and out_data hold their last values.
- dresp_addr_ok and dresp_data_ok are ignored in IDLE. This covers stray responses after reset.

## Timing
- Reset (resetn=0, asynchronous): state=IDLE, in_ready=1, dreq_valid=0, out_valid=0, out_wen=0, out_exc=0, out_dst=0, out_data=0.
- A reset mid-transaction abandons the access. Nothing is written back.
- NONE op or misaligned op transferred at edge T: out_valid=1 in cycle T+1. Throughput is 1 per cycle.
- Memory op transferred at T: REQ is entered at T+1. The earliest completion is addr_ok && data_ok in cycle T+1, giving out_valid in cycle T+2.
- Each bus wait cycle adds one cycle of latency. in_ready=0 from T+1 through the completion cycle.
- in_ready returns to 1 in the cycle after completion, the same cycle out_valid=1.
- All outputs are registered or decoded from state plus latched registers. There is no combinational path from dresp_* to any output.

## Test plan
- Reset: hold resetn=0 mid-REQ → dreq_valid=0, in_ready=1 and out_valid=0 immediately. After release, a stray data_ok produces no out_valid.
- ALU passthrough: three back-to-back NONE ops with addr=0x10, 0x20, 0x30, dst=1,2,3 → out_valid on three consecutive cycles, out_data=0x10, 0x20, 0x30 in order.
- LB, addr=0x1003, dresp_data=0x0000_0000_8000_0000: addr_ok && data_ok in the first REQ cycle → dreq_size=0, dreq_strobe=0x00, out_data=0xFFFF_FFFF_FFFF_FF80, out_valid at T+2.
  - Same access as LBU → out_data=0x80.
- SH, addr=0x1006, wdata=0xBEEF, addr_ok delayed 2 cycles and data_ok 1 cycle after that → dreq_strobe=0xC0, dreq_data=0xBEEF_0000_0000_0000, fields stable while waiting, out_valid at T+5 with out_wen=0.
- LW, addr=0x1002 → no dreq_valid, out_exc=1, out_wen=0, out_valid at T+1.
- LD with addr_ok at T+1 and data_ok at T+4, in_valid held high throughout → in_ready=0 for T+1..T+4, the next instruction transfers at the edge ending T+5, and exactly one out_valid occurs for the LD.

Source files
------------

// File: rtl/memory_access.sv
// Memory-access stage of the RV64 pipeline: issues loads/stores on the data bus,
// lane-aligns store data, extends load data and registers the writeback bundle.
module memory_access #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mem_op,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [REG_AW-1:0] in_dst,
    input  logic              in_wen,
    output logic              dreq_valid,
    output logic [XLEN-1:0]   dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [XLEN-1:0]   dresp_data,
    output logic              out_valid,
    output logic [REG_AW-1:0] out_dst,
    output logic              out_wen,
    output logic [XLEN-1:0]   out_data,
    output logic              out_exc
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LD  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_LHU = 4'd6;
    localparam logic [3:0] OP_LWU = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_SD  = 4'd11;

    function automatic logic is_mem(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SD);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SD);
    endfunction

    // log2 of the access width in bytes
    function automatic logic [1:0] op_size(input logic [3:0] op);
        logic [1:0] sz;
        case (op)
            OP_LH, OP_LHU, OP_SH: sz = 2'd1;
            OP_LW, OP_LWU, OP_SW: sz = 2'd2;
            OP_LD, OP_SD:         sz = 2'd3;
            default:              sz = 2'd0;
        endcase
        return sz;
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [2:0] off);
        logic bad;
        case (op_size(op))
            2'd1:    bad = off[0] != 1'b0;
            2'd2:    bad = off[1:0] != 2'b00;
            2'd3:    bad = off != 3'b000;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [REG_AW-1:0]   dst_q, dst_d;
    logic                wen_q, wen_d;
    logic                out_valid_q, out_valid_d;
    logic [REG_AW-1:0]   out_dst_q, out_dst_d;
    logic                out_wen_q, out_wen_d;
    logic [XLEN-1:0]     out_data_q, out_data_d;
    logic                out_exc_q, out_exc_d;

    logic [5:0]          lane_shift;
    logic [XLEN-1:0]     rd_shifted;
    logic [XLEN-1:0]     load_data;
    logic [7:0]          size_mask;
    logic                complete;

    assign lane_shift = {addr_q[2:0], 3'b000};
    assign rd_shifted = dresp_data >> lane_shift;

    always_comb begin
        load_data = rd_shifted;
        case (op_q)
            OP_LB:   load_data = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
            OP_LH:   load_data = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            OP_LW:   load_data = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            OP_LBU:  load_data = {56'd0, rd_shifted[7:0]};
            OP_LHU:  load_data = {48'd0, rd_shifted[15:0]};
            OP_LWU:  load_data = {32'd0, rd_shifted[31:0]};
            default: load_data = rd_shifted;
        endcase
    end

    always_comb begin
        case (op_size(op_q))
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            2'd3:    size_mask = 8'hFF;
            default: size_mask = 8'h01;
        endcase
    end

    // Request fields come only from latched state, so dresp_* never reaches an output.
    assign in_ready    = (state_q == S_IDLE);
    assign dreq_valid  = (state_q == S_REQ);
    assign dreq_addr   = addr_q;
    assign dreq_size   = {1'b0, op_size(op_q)};
    assign dreq_strobe = is_store(op_q) ? (size_mask << addr_q[2:0]) : 8'h00;
    assign dreq_data   = wdata_q << lane_shift;

    assign out_valid = out_valid_q;
    assign out_dst   = out_dst_q;
    assign out_wen   = out_wen_q;
    assign out_data  = out_data_q;
    assign out_exc   = out_exc_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        dst_d       = dst_q;
        wen_d       = wen_q;
        out_valid_d = 1'b0;
        out_dst_d   = out_dst_q;
        out_wen_d   = out_wen_q;
        out_data_d  = out_data_q;
        out_exc_d   = out_exc_q;
        complete    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!is_mem(in_mem_op)) begin
                        out_valid_d = 1'b1;
                        out_dst_d   = in_dst;
                        out_wen_d   = in_wen;
                        out_data_d  = in_addr;
                        out_exc_d   = 1'b0;
                    end else if (misaligned(in_mem_op, in_addr[2:0])) begin
                        out_valid_d = 1'b1;
                        out_dst_d   = in_dst;
                        out_wen_d   = 1'b0;
                        out_data_d  = '0;
                        out_exc_d   = 1'b1;
                    end else begin
                        op_d    = in_mem_op;
                        addr_d  = in_addr;
                        wdata_d = in_wdata;
                        dst_d   = in_dst;
                        wen_d   = in_wen;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            out_valid_d = 1'b1;
            out_dst_d   = dst_q;
            out_exc_d   = 1'b0;
            if (is_store(op_q)) begin
                out_wen_d  = 1'b0;
                out_data_d = '0;
            end else begin
                out_wen_d  = wen_q;
                out_data_d = load_data;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dst_q       <= '0;
            wen_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_dst_q   <= '0;
            out_wen_q   <= 1'b0;
            out_data_q  <= '0;
            out_exc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            dst_q       <= dst_d;
            wen_q       <= wen_d;
            out_valid_q <= out_valid_d;
            out_dst_q   <= out_dst_d;
            out_wen_q   <= out_wen_d;
            out_data_q  <= out_data_d;
            out_exc_q   <= out_exc_d;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed scenarios plus randomized ops, checked
// against a byte-level reference model of the load/store rules.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_mem_op;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_dst;
    logic        in_wen;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid;
    logic [4:0]  out_dst;
    logic        out_wen;
    logic [63:0] out_data;
    logic        out_exc;

    int checks = 0;
    int errors = 0;

    memory_access dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_mem_op(in_mem_op),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_dst(in_dst), .in_wen(in_wen),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_dst(out_dst), .out_wen(out_wen),
        .out_data(out_data), .out_exc(out_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [3:0] op);
        case (op)
            4'd1, 4'd5, 4'd8:  return 1;
            4'd2, 4'd6, 4'd9:  return 2;
            4'd3, 4'd7, 4'd10: return 4;
            4'd4, 4'd11:       return 8;
            default:           return 0;
        endcase
    endfunction

    function automatic bit m_is_load(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd7;
    endfunction

    function automatic bit m_is_store(input logic [3:0] op);
        return op >= 4'd8 && op <= 4'd11;
    endfunction

    function automatic bit m_misaligned(input logic [3:0] op, input logic [63:0] addr);
        int n = nbytes(op);
        return (n > 1) && ((addr % n) != 0);
    endfunction

    function automatic logic [2:0] m_size(input logic [3:0] op);
        int n = nbytes(op);
        return (n == 8) ? 3'd3 : (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
    endfunction

    function automatic logic [7:0] m_strobe(input logic [3:0] op, input logic [63:0] addr);
        int n = nbytes(op);
        int off = int'(addr % 8);
        int s = ((1 << n) - 1) << off;
        return m_is_store(op) ? 8'(s) : 8'h00;
    endfunction

    function automatic logic [63:0] m_load(input logic [3:0] op, input logic [63:0] addr,
                                           input logic [63:0] rdata);
        int n = nbytes(op);
        int off = int'(addr % 8);
        logic [63:0] v = rdata >> (8 * off);
        logic [63:0] mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
        v = v & mask;
        if ((op == 4'd1 || op == 4'd2 || op == 4'd3) && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- transaction driver ----------------
    // Starts and ends on a falling edge; ends in the cycle where the result is visible.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [4:0] dst, input logic wen,
                          input logic [63:0] rdata, input int a_d, input int d_d,
                          input bit hold_next, input logic [63:0] next_addr,
                          input logic [4:0] next_dst);
        int n;
        logic [63:0] exp_data;
        logic exp_wen;
        check({tag, " ready_pre"}, in_ready, 1'b1);
        in_valid = 1'b1; in_mem_op = op; in_addr = addr; in_wdata = wdata;
        in_dst = dst; in_wen = wen;
        @(negedge clk);
        if (nbytes(op) == 0 || m_misaligned(op, addr)) begin
            in_valid = 1'b0;
            check({tag, " out_valid"}, out_valid, 1'b1);
            check({tag, " dreq_valid"}, dreq_valid, 1'b0);
            check({tag, " in_ready"}, in_ready, 1'b1);
            if (nbytes(op) == 0) begin
                check({tag, " out_exc"}, out_exc, 1'b0);
                check({tag, " out_wen"}, out_wen, wen);
                check({tag, " out_data"}, out_data, addr);
                check({tag, " out_dst"}, out_dst, dst);
            end else begin
                check({tag, " out_exc"}, out_exc, 1'b1);
                check({tag, " out_wen"}, out_wen, 1'b0);
                check({tag, " out_data"}, out_data, 64'd0);
            end
            $display("txn %s op=%0d addr=0x%0h -> data=0x%0h exc=%0b", tag, op, addr, out_data, out_exc);
            return;
        end
        n = a_d + d_d;
        for (int c = 0; c <= n; c++) begin
            check({tag, " wait_out_valid"}, out_valid, 1'b0);
            check({tag, " wait_in_ready"}, in_ready, 1'b0);
            check({tag, " dreq_valid"}, dreq_valid, (c <= a_d) ? 1'b1 : 1'b0);
            if (c <= a_d) begin
                check({tag, " dreq_addr"}, dreq_addr, addr);
                check({tag, " dreq_size"}, dreq_size, m_size(op));
                check({tag, " dreq_strobe"}, dreq_strobe, m_strobe(op, addr));
                if (m_is_store(op))
                    check({tag, " dreq_data"}, dreq_data, wdata << (8 * (addr % 8)));
            end
            if (c == 0) begin
                if (hold_next) begin
                    in_mem_op = 4'd0; in_addr = next_addr; in_dst = next_dst; in_wen = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            dresp_addr_ok = (c == a_d);
            dresp_data_ok = (c == n);
            dresp_data = (c == n) ? rdata : {$urandom, $urandom};
            @(negedge clk);
        end
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        exp_wen  = m_is_load(op) ? wen : 1'b0;
        exp_data = m_is_load(op) ? m_load(op, addr, rdata) : 64'd0;
        check({tag, " out_valid"}, out_valid, 1'b1);
        check({tag, " in_ready_done"}, in_ready, 1'b1);
        check({tag, " dreq_valid_done"}, dreq_valid, 1'b0);
        check({tag, " out_exc"}, out_exc, 1'b0);
        check({tag, " out_dst"}, out_dst, dst);
        check({tag, " out_wen"}, out_wen, exp_wen);
        check({tag, " out_data"}, out_data, exp_data);
        $display("txn %s op=%0d addr=0x%0h lat=%0d -> wen=%0b data=0x%0h", tag, op, addr, n + 2, out_wen, out_data);
        if (hold_next) begin
            @(negedge clk);
            in_valid = 1'b0;
            check({tag, " next_out_valid"}, out_valid, 1'b1);
            check({tag, " next_out_data"}, out_data, next_addr);
            check({tag, " next_out_dst"}, out_dst, next_dst);
            $display("txn %s-next NONE addr=0x%0h -> data=0x%0h", tag, next_addr, out_data);
        end
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_mem_op = '0; in_addr = '0; in_wdata = '0;
        in_dst = '0; in_wen = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready, 1'b1);
        check("rst dreq_valid", dreq_valid, 1'b0);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_wen", out_wen, 1'b0);
        check("rst out_exc", out_exc, 1'b0);
        check("rst out_dst", out_dst, 5'd0);
        check("rst out_data", out_data, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // reset asserted while a load sits in REQ
        in_valid = 1'b1; in_mem_op = 4'd4; in_addr = 64'h2000; in_dst = 5'd7; in_wen = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("midreq dreq_valid", dreq_valid, 1'b1);
        resetn = 1'b0;
        #1;
        check("midreq_rst dreq_valid", dreq_valid, 1'b0);
        check("midreq_rst in_ready", in_ready, 1'b1);
        check("midreq_rst out_valid", out_valid, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h1234;
        @(negedge clk);
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        check("stray out_valid", out_valid, 1'b0);
        check("stray in_ready", in_ready, 1'b1);
        check("stray out_wen", out_wen, 1'b0);
        $display("txn reset-mid-REQ and stray response handled");

        run_op("alu0", 4'd0, 64'h10, 64'd0, 5'd1, 1'b1, 64'd0, 0, 0, 1'b0, 64'd0, 5'd0);
        run_op("alu1", 4'd0, 64'h20, 64'd0, 5'd2, 1'b1, 64'd0, 0, 0, 1'b0, 64'd0, 5'd0);
        run_op("alu2", 4'd0, 64'h30, 64'd0, 5'd3, 1'b1, 64'd0, 0, 0, 1'b0, 64'd0, 5'd0);
        run_op("lb", 4'd1, 64'h1003, 64'd0, 5'd5, 1'b1, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 64'd0, 5'd0);
        check("lb value", out_data, 64'hFFFF_FFFF_FFFF_FF80);
        run_op("lbu", 4'd5, 64'h1003, 64'd0, 5'd5, 1'b1, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 64'd0, 5'd0);
        check("lbu value", out_data, 64'h80);
        run_op("sh", 4'd9, 64'h1006, 64'hBEEF, 5'd6, 1'b1, 64'd0, 2, 1, 1'b0, 64'd0, 5'd0);
        run_op("lw_mis", 4'd3, 64'h1002, 64'd0, 5'd8, 1'b1, 64'd0, 0, 0, 1'b0, 64'd0, 5'd0);
        run_op("ld_hold", 4'd4, 64'h3000, 64'd0, 5'd9, 1'b1, 64'hDEAD_BEEF_0123_4567, 0, 3,
               1'b1, 64'h44, 5'd10);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            logic [63:0] addr;
            int n;
            op = 4'($urandom_range(0, 15));
            addr = {$urandom, $urandom};
            n = nbytes(op);
            if (n > 1 && $urandom_range(0, 3) != 0) addr[2:0] = 3'($urandom_range(0, 7) & ~(n - 1));
            run_op("rand", op, addr, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                   {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'b0, 64'd0, 5'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
